// File: rtl/dphy_master_burst.sv
// D-PHY HS burst transmitter: unmaps a 32-bit packet word stream onto DATA_LANES byte lanes
// and frames each packet with the LP/HS start-of-transmission and end-of-transmission sequences.
module dphy_master_burst #(
    parameter int unsigned DATA_LANES        = 2,
    parameter int unsigned LPX_CYCLES        = 2,
    parameter int unsigned HS_PREPARE_CYCLES = 3,
    parameter int unsigned HS_ZERO_CYCLES    = 4,
    parameter int unsigned HS_TRAIL_CYCLES   = 3,
    parameter int unsigned HS_EXIT_CYCLES    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [31:0]             data_i,
    input  logic                    valid_i,
    input  logic                    eop_i,
    output logic                    ready_o,
    output logic [DATA_LANES*8-1:0] hs_data_o,
    output logic                    hs_en_o,
    output logic [DATA_LANES-1:0]   lp_p_o,
    output logic [DATA_LANES-1:0]   lp_n_o,
    output logic                    busy_o,
    output logic                    underflow_o
);

    localparam int unsigned DW     = DATA_LANES * 8;
    localparam int unsigned PHASES = 4 / DATA_LANES;

    localparam logic [7:0] LPX_LOAD   = 8'(LPX_CYCLES - 1);
    localparam logic [7:0] PREP_LOAD  = 8'(HS_PREPARE_CYCLES - 1);
    localparam logic [7:0] ZERO_LOAD  = 8'(HS_ZERO_CYCLES - 1);
    localparam logic [7:0] TRAIL_LOAD = 8'(HS_TRAIL_CYCLES - 1);
    localparam logic [7:0] EXIT_LOAD  = 8'(HS_EXIT_CYCLES - 1);
    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LP01,
        S_LP00,
        S_HS_ZERO,
        S_SYNC,
        S_DATA,
        S_TRAIL,
        S_EXIT
    } state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [1:0]  phase_q;
    logic [31:0] word_q;
    logic        eop_q;

    logic last_phase;
    logic cnt_done;
    logic more_words;

    assign last_phase = (phase_q == LAST_PHASE);
    assign cnt_done   = (cnt_q == 8'd0);
    assign more_words = last_phase && !eop_q;

    // The word register shifts down one phase per cycle, so the bytes of the current
    // phase always sit in the low lanes; on exit from DATA it still holds the last bytes sent.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            word_q  <= '0;
            eop_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (valid_i) begin
                        state_q <= S_LP01;
                        cnt_q   <= LPX_LOAD;
                    end
                end
                S_LP01: begin
                    if (cnt_done) begin
                        state_q <= S_LP00;
                        cnt_q   <= PREP_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_LP00: begin
                    if (cnt_done) begin
                        state_q <= S_HS_ZERO;
                        cnt_q   <= ZERO_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_HS_ZERO: begin
                    if (cnt_done) begin
                        state_q <= S_SYNC;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_SYNC: begin
                    word_q  <= data_i;
                    eop_q   <= eop_i;
                    phase_q <= '0;
                    state_q <= S_DATA;
                end
                S_DATA: begin
                    if (!last_phase) begin
                        phase_q <= phase_q + 2'd1;
                        word_q  <= word_q >> DW;
                    end else if (more_words && valid_i) begin
                        word_q  <= data_i;
                        eop_q   <= eop_i;
                        phase_q <= '0;
                    end else begin
                        state_q <= S_TRAIL;
                        cnt_q   <= TRAIL_LOAD;
                    end
                end
                S_TRAIL: begin
                    if (cnt_done) begin
                        state_q <= S_EXIT;
                        cnt_q   <= EXIT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_EXIT: begin
                    if (cnt_done) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign ready_o     = (state_q == S_SYNC) || ((state_q == S_DATA) && more_words);
    assign underflow_o = (state_q == S_DATA) && more_words && !valid_i;

    // Trail byte per lane is ~bit7 of that lane's last byte replicated; multiplying the
    // isolated 0/1 per byte by 0xFF fans it out without carries between bytes.
    always_comb begin
        hs_en_o   = 1'b0;
        hs_data_o = '0;
        lp_p_o    = '0;
        lp_n_o    = '0;
        case (state_q)
            S_IDLE, S_EXIT: begin
                lp_p_o = '1;
                lp_n_o = '1;
            end
            S_LP01: begin
                lp_n_o = '1;
            end
            S_LP00: begin
            end
            S_HS_ZERO: begin
                hs_en_o = 1'b1;
            end
            S_SYNC: begin
                hs_en_o   = 1'b1;
                hs_data_o = {DATA_LANES{8'hB8}};
            end
            S_DATA: begin
                hs_en_o   = 1'b1;
                hs_data_o = word_q[DW-1:0];
            end
            S_TRAIL: begin
                hs_en_o   = 1'b1;
                hs_data_o = ~DW'(((word_q >> 7) & 32'h0101_0101) * 32'd255);
            end
            default: begin
                lp_p_o = '1;
                lp_n_o = '1;
            end
        endcase
    end

endmodule

// File: tb/tb_dphy_master_burst.sv
// Directed bench for dphy_master_burst with 1-, 2- and 4-lane instances checked cycle by cycle.
module tb_dphy_master_burst;

    localparam int L11 = 0;
    localparam int L01 = 1;
    localparam int L00 = 2;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic        valid;
    logic        eop;
    int          sel;

    int n_tests = 0;
    int n_fail  = 0;

    logic       v1, v2, v4;
    logic       r1, r2, r4;
    logic       en1, en2, en4;
    logic       b1, b2, b4;
    logic       u1, u2, u4;
    logic [7:0]  hd1;
    logic [15:0] hd2;
    logic [31:0] hd4;
    logic [0:0]  p1, n1;
    logic [1:0]  p2, n2;
    logic [3:0]  p4, n4;

    assign v1 = valid && (sel == 1);
    assign v2 = valid && (sel == 2);
    assign v4 = valid && (sel == 4);

    dphy_master_burst #(.DATA_LANES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(v1), .eop_i(eop),
        .ready_o(r1), .hs_data_o(hd1), .hs_en_o(en1), .lp_p_o(p1), .lp_n_o(n1),
        .busy_o(b1), .underflow_o(u1)
    );

    dphy_master_burst #(.DATA_LANES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(v2), .eop_i(eop),
        .ready_o(r2), .hs_data_o(hd2), .hs_en_o(en2), .lp_p_o(p2), .lp_n_o(n2),
        .busy_o(b2), .underflow_o(u2)
    );

    dphy_master_burst #(.DATA_LANES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(v4), .eop_i(eop),
        .ready_o(r4), .hs_data_o(hd4), .hs_en_o(en4), .lp_p_o(p4), .lp_n_o(n4),
        .busy_o(b4), .underflow_o(u4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        o_en, o_rdy, o_busy, o_uf;
    logic [31:0] o_data;
    logic [3:0]  o_p, o_n;

    always_comb begin
        if (sel == 1) begin
            o_en = en1; o_rdy = r1; o_busy = b1; o_uf = u1;
            o_data = {24'h0, hd1}; o_p = {3'b0, p1}; o_n = {3'b0, n1};
        end else if (sel == 2) begin
            o_en = en2; o_rdy = r2; o_busy = b2; o_uf = u2;
            o_data = {16'h0, hd2}; o_p = {2'b0, p2}; o_n = {2'b0, n2};
        end else begin
            o_en = en4; o_rdy = r4; o_busy = b4; o_uf = u4;
            o_data = hd4; o_p = p4; o_n = n4;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Checks every output of the selected instance for the current cycle, then advances one clock.
    task automatic cyc(input string t, input int lp, input logic en, input logic [31:0] dat,
                       input logic rdy, input logic bsy, input logic uf);
        logic [3:0] m;
        logic [3:0] ep, en_n;
        #1;
        m    = (sel == 1) ? 4'h1 : (sel == 2) ? 4'h3 : 4'hF;
        ep   = (lp == L11) ? m : 4'h0;
        en_n = (lp == L00) ? 4'h0 : m;
        check_eq({t, ".hs_en"}, 32'(o_en), 32'(en));
        check_eq({t, ".hs_data"}, o_data, dat);
        check_eq({t, ".lp_p"}, 32'(o_p), 32'(ep));
        check_eq({t, ".lp_n"}, 32'(o_n), 32'(en_n));
        check_eq({t, ".ready"}, 32'(o_rdy), 32'(rdy));
        check_eq({t, ".busy"}, 32'(o_busy), 32'(bsy));
        check_eq({t, ".underflow"}, 32'(o_uf), 32'(uf));
        @(posedge clk);
        #1;
    endtask

    task automatic preamble(input string t);
        repeat (2) cyc({t, ".lp01"}, L01, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc({t, ".lp00"}, L00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc({t, ".hszero"}, L00, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic tail(input string t, input logic [31:0] trail);
        repeat (3) cyc({t, ".trail"}, L00, 1'b1, trail, 1'b0, 1'b1, 1'b0);
        repeat (2) cyc({t, ".exit"}, L11, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic burst_c4(input string t, input logic hold);
        data  = 32'hC433_2211;
        eop   = 1'b1;
        valid = 1'b1;
        cyc({t, ".idle"}, L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        preamble(t);
        cyc({t, ".sync"}, L00, 1'b1, 32'hB8B8, 1'b1, 1'b1, 1'b0);
        if (!hold) valid = 1'b0;
        cyc({t, ".d0"}, L00, 1'b1, 32'h2211, 1'b0, 1'b1, 1'b0);
        cyc({t, ".d1"}, L00, 1'b1, 32'hC433, 1'b0, 1'b1, 1'b0);
        tail(t, 32'h00FF);
    endtask

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        eop   = 1'b0;
        data  = 32'h0;
        sel   = 2;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        sel = 1; cyc("rst1", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        sel = 2; cyc("rst2", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        sel = 4; cyc("rst4", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        sel = 2;
        burst_c4("single", 1'b0);
        cyc("single.after", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        data = 32'h0302_0100; eop = 1'b0; valid = 1'b1;
        cyc("b2b.idle", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        preamble("b2b");
        cyc("b2b.sync", L00, 1'b1, 32'hB8B8, 1'b1, 1'b1, 1'b0);
        data = 32'h0706_0504;
        cyc("b2b.w0p0", L00, 1'b1, 32'h0100, 1'b0, 1'b1, 1'b0);
        cyc("b2b.w0p1", L00, 1'b1, 32'h0302, 1'b1, 1'b1, 1'b0);
        data = 32'h0B0A_0908; eop = 1'b1;
        cyc("b2b.w1p0", L00, 1'b1, 32'h0504, 1'b0, 1'b1, 1'b0);
        cyc("b2b.w1p1", L00, 1'b1, 32'h0706, 1'b1, 1'b1, 1'b0);
        valid = 1'b0; eop = 1'b0;
        cyc("b2b.w2p0", L00, 1'b1, 32'h0908, 1'b0, 1'b1, 1'b0);
        cyc("b2b.w2p1", L00, 1'b1, 32'h0B0A, 1'b0, 1'b1, 1'b0);
        tail("b2b", 32'hFFFF);
        cyc("b2b.after", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        data = 32'h4433_2211; eop = 1'b0; valid = 1'b1;
        cyc("uf.idle", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        preamble("uf");
        cyc("uf.sync", L00, 1'b1, 32'hB8B8, 1'b1, 1'b1, 1'b0);
        valid = 1'b0;
        cyc("uf.p0", L00, 1'b1, 32'h2211, 1'b0, 1'b1, 1'b0);
        cyc("uf.p1", L00, 1'b1, 32'h4433, 1'b1, 1'b1, 1'b1);
        tail("uf", 32'hFFFF);
        cyc("uf.idle2", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc("uf.idle3", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        data = 32'h1234_5678; eop = 1'b1; valid = 1'b1;
        cyc("rsthz.idle", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) cyc("rsthz.lp01", L01, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc("rsthz.lp00", L00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        cyc("rsthz.hz0", L00, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        valid = 1'b0; rst = 1'b1;
        cyc("rsthz.hz1", L00, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        cyc("rsthz.post", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cyc("rsthz.stay", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        sel = 4;
        data = 32'h4433_2211; eop = 1'b0; valid = 1'b1;
        cyc("x4.idle", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        preamble("x4");
        cyc("x4.sync", L00, 1'b1, 32'hB8B8_B8B8, 1'b1, 1'b1, 1'b0);
        data = 32'h8877_6655; eop = 1'b1;
        cyc("x4.w0", L00, 1'b1, 32'h4433_2211, 1'b1, 1'b1, 1'b0);
        valid = 1'b0; eop = 1'b0;
        cyc("x4.w1", L00, 1'b1, 32'h8877_6655, 1'b0, 1'b1, 1'b0);
        tail("x4", 32'h00FF_FFFF);
        cyc("x4.after", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        sel = 1;
        data = 32'h4433_2211; eop = 1'b1; valid = 1'b1;
        cyc("x1.idle", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        preamble("x1");
        cyc("x1.sync", L00, 1'b1, 32'hB8, 1'b1, 1'b1, 1'b0);
        valid = 1'b0; eop = 1'b0;
        cyc("x1.p0", L00, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
        cyc("x1.p1", L00, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
        cyc("x1.p2", L00, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
        cyc("x1.p3", L00, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0);
        tail("x1", 32'hFF);
        cyc("x1.after", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        sel = 2;
        burst_c4("hold1", 1'b1);
        burst_c4("hold2", 1'b1);
        valid = 1'b0;
        cyc("hold.after", L11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/dphy_master_burst.md
Name: dphy_master_burst

Overview:
- HS burst transmitter for a D-PHY data lane group.
- Takes a 32-bit packet word stream in the byte clock domain and unmaps each word onto DATA_LANES byte lanes. This is the exact inverse of the receive-side 32-bit mapper.
- Wraps every packet in the lane start-of-transmission sequence (LP-11, LP-01, LP-00, HS-zero, sync byte 0xB8) and the end-of-transmission sequence (HS-trail, LP-11 exit).
- Feeds per-lane OSERDES data and LP drivers in CSI-2 loopback/test-pattern transmitters.

Parameters:
- DATA_LANES, 2: number of lanes; legal values 1, 2, 4.
- LPX_CYCLES, 2: clk_i cycles spent in LP-01, range 1..255.
- HS_PREPARE_CYCLES, 3: clk_i cycles spent in LP-00, range 1..255.
- HS_ZERO_CYCLES, 4: cycles of HS 0x00 before sync, range 1..255.
- HS_TRAIL_CYCLES, 3: cycles of trail bytes, range 1..255.
- HS_EXIT_CYCLES, 2: cycles of LP-11 after trail before a new burst may start, range 1..255.

Ports:
- clk_i  in  1  byte clock.
- rst_i  in  1  synchronous, active-high reset.
- data_i  in  32  packet word; byte 0 = data_i[7:0].
- valid_i  in  1  data_i valid.
- eop_i  in  1  last word of the packet; qualified by valid_i.
- ready_o  out  1  word accepted when valid_i && ready_o.
- hs_data_o  out  DATA_LANES*8  per-lane byte; lane i = bits [8i+7:8i]; bit 0 is sent first.
- hs_en_o  out  1  HS driver enable; 0 = LP drivers own the lanes.
- lp_p_o  out  DATA_LANES  LP Dp level.
- lp_n_o  out  DATA_LANES  LP Dn level.
- busy_o  out  1  high in every state except IDLE.
- underflow_o  out  1  one-cycle pulse when the stream starves mid-packet.

Behaviour:
- Reset (synchronous, active-high), effective the cycle after rst_i is sampled high, regardless of state:
  - state = IDLE; all counters cleared; word register cleared.
  - hs_en_o = 0; hs_data_o = 0; lp_p_o / lp_n_o = all 1.
  - ready_o = 0; busy_o = 0; underflow_o = 0.
- Output timing:
  - All outputs are decoded from registered state, counter and word register.
  - ready_o depends only on state and phase, never on valid_i.
- Per-state outputs (LP levels apply to all lanes):
  - IDLE: LP-11, hs_en_o = 0, hs_data_o = 0. When valid_i = 1, go to LP01 next cycle. valid_i is not consumed here.
  - LP01: lp_p_o = 0, lp_n_o = 1, for LPX_CYCLES cycles, then LP00.
  - LP00: lp_p_o = 0, lp_n_o = 0, for HS_PREPARE_CYCLES cycles, then HS_ZERO.
  - HS_ZERO: hs_en_o = 1, hs_data_o = 0, for HS_ZERO_CYCLES cycles, then SYNC. LP outputs stay 0 from HS_ZERO through TRAIL.
  - SYNC: one cycle; every lane = 0xB8; ready_o = 1; capture data_i/eop_i; go to DATA with phase = 0.
  - DATA: PHASES = 4/DATA_LANES cycles per word.
    - In phase k, lane i = byte (k*DATA_LANES + i) of the word register.
    - ready_o = 1 in phase PHASES-1 only if the current word has eop = 0.
    - On that cycle with valid_i = 1: load the new word and wrap phase to 0, so there are no gap cycles.
    - On that cycle with valid_i = 0: pulse underflow_o for one cycle and go to TRAIL, as if eop had been set.
    - Last phase of an eop word: go to TRAIL; ready_o = 0.
  - TRAIL: hs_en_o = 1; each lane outputs {8{~b}}, where b = bit 7 of the last byte sent on that lane. Lasts HS_TRAIL_CYCLES cycles, then EXIT.
  - EXIT: LP-11, hs_en_o = 0, for HS_EXIT_CYCLES cycles, then IDLE. valid_i is ignored here.
- A new burst needs at least 1 IDLE cycle: valid_i held through EXIT gives IDLE for 1 cycle, then LP01.
- Upstream rule: once valid_i is raised it must stay high until the handshake. A word is in flight from the IDLE detection until the SYNC handshake.
- Counters are 8-bit, load N-1 on state entry and advance the state at 0.
- DATA_LANES = 4: PHASES = 1, and ready_o can be high on every DATA cycle.

Test Plan (DATA_LANES = 2 and default timing unless noted):
- Single word 0xC4332211 with eop = 1 held from IDLE:
  - Timeline: LP01 for 2 cycles, LP00 for 3, hs_data_o = 0x0000 for 4, then 0xB8B8, 0x2211, 0xC433.
  - Then trail 0x00FF for 3 cycles, then LP-11 with hs_en_o = 0 for 2 cycles, then busy_o = 0.
  - ready_o is high only in the SYNC cycle.
- Three back-to-back words 0x03020100, 0x07060504, 0x0B0A0908, eop on the third:
  - DATA output is 0x0100, 0x0302, 0x0504, 0x0706, 0x0908, 0x0B0A on consecutive cycles.
  - ready_o pulses 3 times.
  - The trail byte is 0xFFFF.
- Underflow: word 1 without eop, then valid_i = 0:
  - underflow_o = 1 for exactly 1 cycle, in the phase-1 cycle.
  - Next state is TRAIL; completes EXIT; returns to IDLE with no further ready_o.
- Reset asserted during HS_ZERO:
  - Next cycle hs_en_o = 0, lp_p_o = lp_n_o = 2'b11, busy_o = 0, hs_data_o = 0.
  - With valid_i = 0, outputs stay in IDLE.
- DATA_LANES = 4, words 0x44332211 and 0x88776655 with eop on the second:
  - hs_data_o = 0xB8B8B8B8, then 0x44332211, then 0x88776655.
  - ready_o is high in SYNC and in the first DATA cycle.
- DATA_LANES = 1: word 0x44332211 yields 0x11, 0x22, 0x33, 0x44; trail = 0xFF.
- valid_i held high through EXIT for a second packet:
  - Exactly 1 IDLE cycle occurs, then LP01.
  - The second burst is cycle-identical to the first.
